// File: rtl/decode_stage.sv
// Registered instruction-decode stage for the toy CPU: valid/ready on both sides,
// load-use and flag-hazard interlocks, illegal-opcode flag and flush.
module decode_stage #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned LOAD_LAT = 2,
   parameter int unsigned FLAG_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [15:0]       i_in_instr,
   input  logic              i_c_flag,
   input  logic              i_z_flag,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [1:0]        o_next_pc_sel,
   output logic              o_reg_data_in_source,
   output logic              o_imm_data,
   output logic              o_reg_file_we,
   output logic              o_mem_we,
   output logic              o_d_addr_sel,
   output logic [1:0]        o_reg_dst,
   output logic [1:0]        o_reg_src1,
   output logic [1:0]        o_reg_src2,
   output logic [3:0]        o_alu_op,
   output logic [DATA_W-1:0] o_instr_data,
   output logic              o_out_illegal
);

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_LD_IMM = 4'b1010;
   localparam logic [3:0] OP_LD_IND = 4'b1011;
   localparam logic [3:0] OP_MV     = 4'b1100;
   localparam logic [3:0] OP_ST_IND = 4'b1101;
   localparam logic [3:0] OP_BR_IMM = 4'b1110;
   localparam logic [3:0] OP_BR_IND = 4'b1111;

   logic [3:0]        w_op;
   logic [1:0]        w_rd;
   logic [1:0]        w_rs1;
   logic [1:0]        w_rs2;
   logic              w_br_taken;
   logic              w_accept;
   logic              w_issue;

   logic [1:0]        w_dec_next_pc_sel;
   logic              w_dec_src;
   logic              w_dec_imm;
   logic              w_dec_we;
   logic              w_dec_mem_we;
   logic              w_dec_addr_sel;
   logic [3:0]        w_dec_alu_op;
   logic [DATA_W-1:0] w_dec_data;
   logic              w_dec_illegal;
   logic              w_reads_rs1;
   logic              w_reads_rs2;
   logic              w_is_branch;

   logic              w_pend_rs1;
   logic              w_pend_rs2;
   logic              w_load_haz;
   logic              w_flag_haz;

   logic              r_out_valid;
   logic [3:0]        r_op;
   logic [1:0]        r_next_pc_sel;
   logic              r_reg_data_in_source;
   logic              r_imm_data;
   logic              r_reg_file_we;
   logic              r_mem_we;
   logic              r_d_addr_sel;
   logic [1:0]        r_reg_dst;
   logic [1:0]        r_reg_src1;
   logic [1:0]        r_reg_src2;
   logic [3:0]        r_alu_op;
   logic [DATA_W-1:0] r_instr_data;
   logic              r_out_illegal;

   logic [LOAD_LAT-1:0] r_sb_vld;
   logic [1:0]          r_sb_rd [LOAD_LAT];
   logic [1:0]          r_flag_cnt;

   assign w_op  = i_in_instr[15:12];
   assign w_rd  = i_in_instr[11:10];
   assign w_rs1 = i_in_instr[9:8];
   assign w_rs2 = i_in_instr[7:6];
   // brFlagSel picks the flag, brFlag is the value it must equal
   assign w_br_taken = ((i_in_instr[11] ? i_z_flag : i_c_flag) == i_in_instr[10]);

   always_comb begin
      w_dec_next_pc_sel = 2'b00;
      w_dec_src         = 1'b0;
      w_dec_imm         = 1'b0;
      w_dec_we          = 1'b0;
      w_dec_mem_we      = 1'b0;
      w_dec_addr_sel    = 1'b0;
      w_dec_alu_op      = 4'b0000;
      w_dec_data        = '0;
      w_dec_illegal     = 1'b0;
      w_reads_rs1       = 1'b0;
      w_reads_rs2       = 1'b0;
      w_is_branch       = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_dec_we    = 1'b1;
            w_reads_rs1 = 1'b1;
            w_reads_rs2 = 1'b1;
         end
         OP_LD_IMM: begin
            w_dec_imm  = 1'b1;
            w_dec_we   = 1'b1;
            w_dec_data = DATA_W'(i_in_instr[7:0]);
         end
         OP_LD_IND: begin
            w_dec_addr_sel = 1'b1;
            w_dec_src      = 1'b1;
            w_dec_we       = 1'b1;
            w_reads_rs1    = 1'b1;
         end
         OP_MV: begin
            w_dec_we     = 1'b1;
            w_dec_alu_op = 4'b1111;
            w_reads_rs1  = 1'b1;
         end
         OP_ST_IND: begin
            w_dec_addr_sel = 1'b1;
            w_dec_mem_we   = 1'b1;
            w_reads_rs1    = 1'b1;
            w_reads_rs2    = 1'b1;
         end
         OP_BR_IMM: begin
            w_is_branch = 1'b1;
            if (w_br_taken) begin
               w_dec_next_pc_sel = 2'b01;
               w_dec_data        = DATA_W'(i_in_instr[7:0]);
            end
         end
         OP_BR_IND: begin
            w_is_branch = 1'b1;
            w_reads_rs1 = 1'b1;
            if (w_br_taken) begin
               w_dec_next_pc_sel = 2'b10;
            end
         end
         default: w_dec_illegal = 1'b1;
      endcase
   end

   // A source is pending while its producing load sits in the output register
   // or in any live scoreboard slot.
   always_comb begin
      w_pend_rs1 = r_out_valid && (r_op == OP_LD_IND) && (r_reg_dst == w_rs1);
      w_pend_rs2 = r_out_valid && (r_op == OP_LD_IND) && (r_reg_dst == w_rs2);
      for (int i = 0; i < int'(LOAD_LAT); i++) begin
         if (r_sb_vld[i] && (r_sb_rd[i] == w_rs1)) w_pend_rs1 = 1'b1;
         if (r_sb_vld[i] && (r_sb_rd[i] == w_rs2)) w_pend_rs2 = 1'b1;
      end
   end

   assign w_load_haz = (w_reads_rs1 && w_pend_rs1) || (w_reads_rs2 && w_pend_rs2);
   assign w_flag_haz = w_is_branch && ((r_out_valid && (r_op == OP_ADD)) || (r_flag_cnt != 2'd0));

   assign o_in_ready = !i_rst && !i_flush && !w_load_haz && !w_flag_haz &&
                       (!r_out_valid || i_out_ready);
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_issue    = r_out_valid && i_out_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid          <= 1'b0;
         r_op                 <= '0;
         r_next_pc_sel        <= '0;
         r_reg_data_in_source <= 1'b0;
         r_imm_data           <= 1'b0;
         r_reg_file_we        <= 1'b0;
         r_mem_we             <= 1'b0;
         r_d_addr_sel         <= 1'b0;
         r_reg_dst            <= '0;
         r_reg_src1           <= '0;
         r_reg_src2           <= '0;
         r_alu_op             <= '0;
         r_instr_data         <= '0;
         r_out_illegal        <= 1'b0;
      end else begin
         if (i_flush) begin
            r_out_valid <= 1'b0;
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
         end else if (w_issue) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            r_op                 <= w_op;
            r_next_pc_sel        <= w_dec_next_pc_sel;
            r_reg_data_in_source <= w_dec_src;
            r_imm_data           <= w_dec_imm;
            r_reg_file_we        <= w_dec_we;
            r_mem_we             <= w_dec_mem_we;
            r_d_addr_sel         <= w_dec_addr_sel;
            r_reg_dst            <= w_rd;
            r_reg_src1           <= w_rs1;
            r_reg_src2           <= w_rs2;
            r_alu_op             <= w_dec_alu_op;
            r_instr_data         <= w_dec_data;
            r_out_illegal        <= w_dec_illegal;
         end
      end
   end

   // Issue bookkeeping is independent of flush: a load or add leaving this
   // cycle still has to be tracked downstream.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sb_vld   <= '0;
         r_flag_cnt <= 2'd0;
         for (int i = 0; i < int'(LOAD_LAT); i++) begin
            r_sb_rd[i] <= 2'd0;
         end
      end else begin
         r_sb_vld[0] <= w_issue && (r_op == OP_LD_IND);
         r_sb_rd[0]  <= r_reg_dst;
         for (int i = 1; i < int'(LOAD_LAT); i++) begin
            r_sb_vld[i] <= r_sb_vld[i-1];
            r_sb_rd[i]  <= r_sb_rd[i-1];
         end
         if (w_issue && (r_op == OP_ADD)) begin
            r_flag_cnt <= 2'(FLAG_LAT);
         end else if (r_flag_cnt != 2'd0) begin
            r_flag_cnt <= r_flag_cnt - 2'd1;
         end
      end
   end

   assign o_out_valid          = r_out_valid;
   assign o_next_pc_sel        = r_next_pc_sel;
   assign o_reg_data_in_source = r_reg_data_in_source;
   assign o_imm_data           = r_imm_data;
   assign o_reg_file_we        = r_reg_file_we;
   assign o_mem_we             = r_mem_we;
   assign o_d_addr_sel         = r_d_addr_sel;
   assign o_reg_dst            = r_reg_dst;
   assign o_reg_src1           = r_reg_src1;
   assign o_reg_src2           = r_reg_src2;
   assign o_alu_op             = r_alu_op;
   assign o_instr_data         = r_instr_data;
   assign o_out_illegal        = r_out_illegal;

endmodule
